// File: rtl/ex_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : ex_result_buffer
//  Purpose  : 2-entry skid buffer holding ALU results for the memory/writeback
//             side, with a synchronous flush. Optional forwarding of the
//             youngest entry is enabled with EXRB_FORWARD_EN.
//  Revision : 1.0
// ============================================================================
module ex_result_buffer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_zero,
   input  logic [4:0]      in_rd,
   input  logic            in_reg_write,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_alu_result,
   output logic            out_alu_zero,
   output logic [4:0]      out_rd,
   output logic            out_reg_write
`ifdef EXRB_FORWARD_EN
   ,
   output logic            fwd_valid,
   output logic [4:0]      fwd_rd,
   output logic [XLEN-1:0] fwd_data
`endif
);

   localparam int c_PAYLOAD_W = XLEN + 7;

   // Encoding is {main_valid, skid_valid}
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_BAD   = 2'b01,
      ST_ONE   = 2'b10,
      ST_FULL  = 2'b11
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [c_PAYLOAD_W-1:0] r_main;
   logic [c_PAYLOAD_W-1:0] r_skid;
   logic [c_PAYLOAD_W-1:0] w_in_payload;
   logic                   w_in_fire;
   logic                   w_out_fire;
   logic                   w_load_main_in;
   logic                   w_load_main_skid;
   logic                   w_load_skid;

   assign in_ready     = ~r_state[0];
   assign out_valid    = r_state[1];
   assign w_in_fire    = in_valid & in_ready;
   assign w_out_fire   = out_valid & out_ready;
   assign w_in_payload = {alu_result, alu_zero, in_rd, in_reg_write};

   always_comb begin
      w_state_next     = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_in_fire) begin
               w_state_next   = ST_ONE;
               w_load_main_in = 1'b1;
            end
         end
         ST_ONE: begin
            if (w_in_fire && w_out_fire) begin
               w_load_main_in = 1'b1;
            end else if (w_in_fire) begin
               w_state_next = ST_FULL;
               w_load_skid  = 1'b1;
            end else if (w_out_fire) begin
               w_state_next = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_out_fire) begin
               w_state_next     = ST_ONE;
               w_load_main_skid = 1'b1;
            end
         end
         default: begin
            // Orphaned skid entry: promote it so it is not lost
            w_state_next     = ST_ONE;
            w_load_main_skid = 1'b1;
         end
      endcase
      // Flush wins; payload loads are suppressed since the data is dead anyway
      if (flush) begin
         w_state_next     = ST_EMPTY;
         w_load_main_in   = 1'b0;
         w_load_main_skid = 1'b0;
         w_load_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Payload only toggles on a load; valid bits alone define visibility
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_load_main_in) begin
            r_main <= w_in_payload;
         end else if (w_load_main_skid) begin
            r_main <= r_skid;
         end
         if (w_load_skid) begin
            r_skid <= w_in_payload;
         end
      end
   end

   assign {out_alu_result, out_alu_zero, out_rd, out_reg_write} = r_main;

`ifdef EXRB_FORWARD_EN
   logic w_young_rw;

   // Youngest entry sits in skid whenever skid is occupied
   assign w_young_rw = r_state[0] ? r_skid[0] : r_main[0];
   assign fwd_rd     = r_state[0] ? r_skid[5:1] : r_main[5:1];
   assign fwd_data   = r_state[0] ? r_skid[c_PAYLOAD_W-1:7] : r_main[c_PAYLOAD_W-1:7];
   assign fwd_valid  = (r_state != ST_EMPTY) & w_young_rw & (fwd_rd != 5'd0);
`endif

endmodule
`default_nettype wire
